// File: rtl/alu_rs_if.sv
// ALU calc interface: the issue bundle from the reservation station to the ALU.
//   master (reservation station): drives calc_enable/calc_code/lhs/rhs/pos_in_iq,
//                                 samples full
//   slave  (ALU):                 samples the calc bundle, drives full
//   calc_enable  issue valid
//   calc_code    op code
//   lhs/rhs      32-bit operands
//   pos_in_iq    destination instruction-queue index
//   full         ALU result slot occupied; no issue while set
interface alu_rs_if #(
    parameter int CALC_W    = 4,
    parameter int IQ_ADDR_W = 4
);
    logic                 calc_enable;
    logic [CALC_W-1:0]    calc_code;
    logic [31:0]          lhs;
    logic [31:0]          rhs;
    logic [IQ_ADDR_W-1:0] pos_in_iq;
    logic                 full;

    modport master (output calc_enable, calc_code, lhs, rhs, pos_in_iq, input full);
    modport slave  (input calc_enable, calc_code, lhs, rhs, pos_in_iq, output full);
endinterface

// File: rtl/alu_rs.sv
// Reservation station in front of the integer ALU.
// Buffers dispatched ops, captures missing operands from the CDB and issues the
// lowest-index entry whose operands are both ready over the ALU calc interface.
// Two-phase operation: update edges (update_stat=1) do wakeup and dispatch,
// issue edges (update_stat=0) select and issue. rdy=0 freezes everything,
// clear_flag_in flushes all entries.
// Ports:
//   clk, rst (async, active low)      clock / reset
//   rdy, update_stat, clear_flag_in   global ready, phase, flush
//   dispatch_*                        new op from decode
//   rs_full_out                       all entries occupied (combinational)
//   cdb_enable_in/idx_in/result_in    common data bus broadcast
//   alu                               calc interface (master side)
module alu_rs #(
    parameter int RS_SIZE   = 8,
    parameter int IQ_ADDR_W = 4,
    parameter int CALC_W    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 update_stat,
    input  logic                 clear_flag_in,
    input  logic                 dispatch_enable_in,
    input  logic [CALC_W-1:0]    dispatch_calc_code_in,
    input  logic [IQ_ADDR_W-1:0] dispatch_pos_in_iq_in,
    input  logic                 dispatch_lhs_ready_in,
    input  logic [31:0]          dispatch_lhs_in,
    input  logic [IQ_ADDR_W-1:0] dispatch_lhs_tag_in,
    input  logic                 dispatch_rhs_ready_in,
    input  logic [31:0]          dispatch_rhs_in,
    input  logic [IQ_ADDR_W-1:0] dispatch_rhs_tag_in,
    output logic                 rs_full_out,
    input  logic                 cdb_enable_in,
    input  logic [IQ_ADDR_W-1:0] cdb_idx_in,
    input  logic [31:0]          cdb_result_in,
    alu_rs_if.master             alu
);
    localparam int IDX_W = $clog2(RS_SIZE);

    // Entry storage; every entry is inspected in parallel each cycle.
    logic [RS_SIZE-1:0]   valid_reg;
    logic [RS_SIZE-1:0]   lhs_rdy_reg;
    logic [RS_SIZE-1:0]   rhs_rdy_reg;
    logic [CALC_W-1:0]    code_reg    [RS_SIZE];
    logic [IQ_ADDR_W-1:0] pos_reg     [RS_SIZE];
    logic [31:0]          lhs_reg     [RS_SIZE];
    logic [31:0]          rhs_reg     [RS_SIZE];
    logic [IQ_ADDR_W-1:0] lhs_tag_reg [RS_SIZE];
    logic [IQ_ADDR_W-1:0] rhs_tag_reg [RS_SIZE];

    logic                 calc_enable_reg;
    logic [CALC_W-1:0]    calc_code_reg;
    logic [31:0]          calc_lhs_reg;
    logic [31:0]          calc_rhs_reg;
    logic [IQ_ADDR_W-1:0] calc_pos_reg;

    logic [RS_SIZE-1:0]   ready_vec;
    logic                 free_found;
    logic [IDX_W-1:0]     free_idx;
    logic                 issue_found;
    logic [IDX_W-1:0]     issue_idx;

    generate
        for (genvar gi = 0; gi < RS_SIZE; gi++) begin : g_ready
            assign ready_vec[gi] = valid_reg[gi] & lhs_rdy_reg[gi] & rhs_rdy_reg[gi];
        end
    endgenerate

    assign rs_full_out = &valid_reg;

    // Lowest-index priority pick: scanning downward lets the lowest hit win.
    always_comb begin
        free_found  = 1'b0;
        free_idx    = '0;
        issue_found = 1'b0;
        issue_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!valid_reg[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (ready_vec[i]) begin
                issue_found = 1'b1;
                issue_idx   = IDX_W'(i);
            end
        end
    end

    // A not-ready dispatched operand whose producer broadcasts on this very
    // edge must be captured now, otherwise the broadcast would be missed.
    logic disp_lhs_bypass;
    logic disp_rhs_bypass;
    assign disp_lhs_bypass = !dispatch_lhs_ready_in && cdb_enable_in &&
                             (dispatch_lhs_tag_in == cdb_idx_in);
    assign disp_rhs_bypass = !dispatch_rhs_ready_in && cdb_enable_in &&
                             (dispatch_rhs_tag_in == cdb_idx_in);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_reg       <= '0;
            lhs_rdy_reg     <= '0;
            rhs_rdy_reg     <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                code_reg[i]    <= '0;
                pos_reg[i]     <= '0;
                lhs_reg[i]     <= '0;
                rhs_reg[i]     <= '0;
                lhs_tag_reg[i] <= '0;
                rhs_tag_reg[i] <= '0;
            end
            calc_enable_reg <= 1'b0;
            calc_code_reg   <= '0;
            calc_lhs_reg    <= '0;
            calc_rhs_reg    <= '0;
            calc_pos_reg    <= '0;
        end else if (rdy) begin
            if (clear_flag_in) begin
                valid_reg       <= '0;
                calc_enable_reg <= 1'b0;
            end else if (update_stat) begin
                calc_enable_reg <= 1'b0;
                // CDB wakeup of waiting operands
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (valid_reg[i] && cdb_enable_in) begin
                        if (!lhs_rdy_reg[i] && lhs_tag_reg[i] == cdb_idx_in) begin
                            lhs_reg[i]     <= cdb_result_in;
                            lhs_rdy_reg[i] <= 1'b1;
                        end
                        if (!rhs_rdy_reg[i] && rhs_tag_reg[i] == cdb_idx_in) begin
                            rhs_reg[i]     <= cdb_result_in;
                            rhs_rdy_reg[i] <= 1'b1;
                        end
                    end
                end
                // Dispatch into the lowest free slot (a free slot is never
                // touched by the wakeup loop above, so there is no overlap).
                if (dispatch_enable_in && free_found) begin
                    valid_reg[free_idx]   <= 1'b1;
                    code_reg[free_idx]    <= dispatch_calc_code_in;
                    pos_reg[free_idx]     <= dispatch_pos_in_iq_in;
                    lhs_tag_reg[free_idx] <= dispatch_lhs_tag_in;
                    rhs_tag_reg[free_idx] <= dispatch_rhs_tag_in;
                    lhs_rdy_reg[free_idx] <= dispatch_lhs_ready_in | disp_lhs_bypass;
                    rhs_rdy_reg[free_idx] <= dispatch_rhs_ready_in | disp_rhs_bypass;
                    lhs_reg[free_idx]     <= disp_lhs_bypass ? cdb_result_in : dispatch_lhs_in;
                    rhs_reg[free_idx]     <= disp_rhs_bypass ? cdb_result_in : dispatch_rhs_in;
                end
            end else begin
                if (!alu.full && issue_found) begin
                    calc_enable_reg      <= 1'b1;
                    calc_code_reg        <= code_reg[issue_idx];
                    calc_lhs_reg         <= lhs_reg[issue_idx];
                    calc_rhs_reg         <= rhs_reg[issue_idx];
                    calc_pos_reg         <= pos_reg[issue_idx];
                    valid_reg[issue_idx] <= 1'b0;
                end else begin
                    calc_enable_reg <= 1'b0;
                end
            end
        end
    end

    assign alu.calc_enable = calc_enable_reg;
    assign alu.calc_code   = calc_code_reg;
    assign alu.lhs         = calc_lhs_reg;
    assign alu.rhs         = calc_rhs_reg;
    assign alu.pos_in_iq   = calc_pos_reg;

endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: directed scenarios plus randomized traffic,
// compared against an entry-table model of the reservation station.
module tb_alu_rs;
    logic        clk;
    logic        rst;
    logic        rdy;
    logic        update_stat;
    logic        clear_flag_in;
    logic        d_en;
    logic [3:0]  d_code;
    logic [3:0]  d_pos;
    logic        d_lr;
    logic [31:0] d_lv;
    logic [3:0]  d_lt;
    logic        d_rr;
    logic [31:0] d_rv;
    logic [3:0]  d_rt;
    logic        rs_full_out;
    logic        cdb_en;
    logic [3:0]  cdb_idx;
    logic [31:0] cdb_val;

    alu_rs_if #(.CALC_W(4), .IQ_ADDR_W(4)) alu_bus ();

    alu_rs #(.RS_SIZE(8), .IQ_ADDR_W(4), .CALC_W(4)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .rdy                   (rdy),
        .update_stat           (update_stat),
        .clear_flag_in         (clear_flag_in),
        .dispatch_enable_in    (d_en),
        .dispatch_calc_code_in (d_code),
        .dispatch_pos_in_iq_in (d_pos),
        .dispatch_lhs_ready_in (d_lr),
        .dispatch_lhs_in       (d_lv),
        .dispatch_lhs_tag_in   (d_lt),
        .dispatch_rhs_ready_in (d_rr),
        .dispatch_rhs_in       (d_rv),
        .dispatch_rhs_tag_in   (d_rt),
        .rs_full_out           (rs_full_out),
        .cdb_enable_in         (cdb_en),
        .cdb_idx_in            (cdb_idx),
        .cdb_result_in         (cdb_val),
        .alu                   (alu_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        bit          v;
        logic [3:0]  code;
        logic [3:0]  pos;
        bit          lr;
        logic [31:0] lv;
        logic [3:0]  lt;
        bit          rr;
        logic [31:0] rv;
        logic [3:0]  rt;
    } ent_t;

    ent_t        m [8];
    logic        m_en;
    logic [3:0]  m_code;
    logic [31:0] m_lhs;
    logic [31:0] m_rhs;
    logic [3:0]  m_pos;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m[i].v = 0;
        m_en = 0; m_code = 0; m_lhs = 0; m_rhs = 0; m_pos = 0;
    endtask

    function automatic bit model_full();
        for (int i = 0; i < 8; i++) if (!m[i].v) return 0;
        return 1;
    endfunction

    task automatic model_edge();
        int slot;
        if (!rdy) return;
        if (clear_flag_in) begin
            for (int i = 0; i < 8; i++) m[i].v = 0;
            m_en = 0;
            return;
        end
        m_en = 0;
        if (update_stat) begin
            if (cdb_en) begin
                for (int i = 0; i < 8; i++) begin
                    if (m[i].v && !m[i].lr && m[i].lt == cdb_idx) begin m[i].lr = 1; m[i].lv = cdb_val; end
                    if (m[i].v && !m[i].rr && m[i].rt == cdb_idx) begin m[i].rr = 1; m[i].rv = cdb_val; end
                end
            end
            slot = -1;
            for (int i = 7; i >= 0; i--) if (!m[i].v) slot = i;
            if (d_en && slot >= 0) begin
                m[slot].v = 1; m[slot].code = d_code; m[slot].pos = d_pos;
                m[slot].lr = d_lr; m[slot].lv = d_lv; m[slot].lt = d_lt;
                m[slot].rr = d_rr; m[slot].rv = d_rv; m[slot].rt = d_rt;
                if (!d_lr && cdb_en && d_lt == cdb_idx) begin m[slot].lr = 1; m[slot].lv = cdb_val; end
                if (!d_rr && cdb_en && d_rt == cdb_idx) begin m[slot].rr = 1; m[slot].rv = cdb_val; end
            end
        end else if (!alu_bus.full) begin
            for (int i = 0; i < 8; i++) begin
                if (m[i].v && m[i].lr && m[i].rr) begin
                    m_en = 1; m_code = m[i].code; m_lhs = m[i].lv;
                    m_rhs = m[i].rv; m_pos = m[i].pos; m[i].v = 0;
                    break;
                end
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        rdy = 1; clear_flag_in = 0; d_en = 0; cdb_en = 0;
        d_code = 0; d_pos = 0; d_lr = 1; d_lv = 0; d_lt = 0;
        d_rr = 1; d_rv = 0; d_rt = 0; cdb_idx = 0; cdb_val = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_en"},   32'(alu_bus.calc_enable), 32'(m_en));
        chk({tag, "_code"}, 32'(alu_bus.calc_code),   32'(m_code));
        chk({tag, "_lhs"},  alu_bus.lhs,              m_lhs);
        chk({tag, "_rhs"},  alu_bus.rhs,              m_rhs);
        chk({tag, "_pos"},  32'(alu_bus.pos_in_iq),   32'(m_pos));
        chk({tag, "_full"}, 32'(rs_full_out),         32'(model_full()));
    endtask

    // One clock edge in the given phase; inputs must already be set.
    task automatic tick(input logic upd, input string tag);
        update_stat = upd;
        model_edge();
        @(posedge clk);
        #1;
        check_outputs(tag);
        if (alu_bus.calc_enable)
            $display("issue %s code=%0d lhs=%0h rhs=%0h pos=%0d", tag,
                     alu_bus.calc_code, alu_bus.lhs, alu_bus.rhs, alu_bus.pos_in_iq);
    endtask

    task automatic disp(input logic [3:0] code, input logic [3:0] pos,
                        input logic lr, input logic [31:0] lv, input logic [3:0] lt,
                        input logic rr, input logic [31:0] rv, input logic [3:0] rt);
        d_en = 1; d_code = code; d_pos = pos;
        d_lr = lr; d_lv = lv; d_lt = lt; d_rr = rr; d_rv = rv; d_rt = rt;
    endtask

    initial begin
        rst = 0;
        update_stat = 1;
        alu_bus.full = 0;
        idle();
        model_reset();
        #2;
        check_outputs("reset");
        #6 rst = 1;

        // basic ready op
        disp(4'd0, 4'd3, 1, 32'd5, 0, 1, 32'd7, 0);
        tick(1, "tp1_upd");
        idle();
        tick(0, "tp1_iss");
        chk("tp1_const_en", 32'(alu_bus.calc_enable), 32'd1);
        chk("tp1_const_lhs", alu_bus.lhs, 32'd5);
        chk("tp1_const_pos", 32'(alu_bus.pos_in_iq), 32'd3);
        tick(1, "tp1_upd2");

        // CDB wakeup
        disp(4'd2, 4'd6, 0, 32'd0, 4'd2, 1, 32'd1, 0);
        tick(1, "tp2_upd");
        idle();
        tick(0, "tp2_wait");
        cdb_en = 1; cdb_idx = 4'd2; cdb_val = 32'h10;
        tick(1, "tp2_cdb");
        idle();
        tick(0, "tp2_iss");
        chk("tp2_const_lhs", alu_bus.lhs, 32'h10);

        // dispatch bypass
        disp(4'd5, 4'd7, 1, 32'd3, 0, 0, 32'd0, 4'd4);
        cdb_en = 1; cdb_idx = 4'd4; cdb_val = 32'd9;
        tick(1, "tp3_upd");
        idle();
        tick(0, "tp3_iss");
        chk("tp3_const_rhs", alu_bus.rhs, 32'd9);

        // fill, drop, wake entry 5
        for (int i = 0; i < 8; i++) begin
            disp(4'(i), 4'(i), 0, 32'd0, 4'(8 + i), 1, 32'(i), 0);
            tick(1, "tp4_fill");
            idle();
            tick(0, "tp4_fill_iss");
        end
        chk("tp4_const_full", 32'(rs_full_out), 32'd1);
        disp(4'd15, 4'd15, 1, 32'd1, 0, 1, 32'd1, 0);
        tick(1, "tp4_drop");
        idle();
        tick(0, "tp4_drop_iss");
        cdb_en = 1; cdb_idx = 4'd13; cdb_val = 32'hABCD;
        tick(1, "tp4_wake");
        idle();
        tick(0, "tp4_iss");
        chk("tp4_const_pos", 32'(alu_bus.pos_in_iq), 32'd5);
        chk("tp4_const_notfull", 32'(rs_full_out), 32'd0);
        clear_flag_in = 1;
        tick(1, "tp4_clr");
        idle();

        // priority with alu_full
        for (int i = 0; i < 7; i++) begin
            disp(4'(i), 4'(i), (i == 1 || i == 6), 32'(100 + i), 4'd15, 1, 32'd0, 0);
            tick(1, "tp5_fill");
            idle();
            alu_bus.full = 1;
            tick(0, "tp5_blocked");
        end
        alu_bus.full = 0;
        tick(0, "tp5_iss1");
        chk("tp5_const_pos1", 32'(alu_bus.pos_in_iq), 32'd1);
        tick(1, "tp5_upd");
        tick(0, "tp5_iss6");
        chk("tp5_const_pos6", 32'(alu_bus.pos_in_iq), 32'd6);

        // clear on issue edge
        clear_flag_in = 1;
        tick(0, "tp6_clr");
        chk("tp6_const_en", 32'(alu_bus.calc_enable), 32'd0);
        idle();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rdy           = ($urandom_range(9) != 0);
            clear_flag_in = ($urandom_range(49) == 0);
            alu_bus.full  = ($urandom_range(3) == 0);
            d_en    = $urandom_range(1);
            d_code  = 4'($urandom);
            d_pos   = 4'($urandom);
            d_lr    = ($urandom_range(2) == 0);
            d_lv    = $urandom;
            d_lt    = 4'($urandom_range(7));
            d_rr    = ($urandom_range(2) == 0);
            d_rv    = $urandom;
            d_rt    = 4'($urandom_range(7));
            cdb_en  = $urandom_range(1);
            cdb_idx = 4'($urandom_range(7));
            cdb_val = $urandom;
            tick(1'(n % 2 == 0), "rnd");
        end

        // asynchronous reset mid-operation
        idle();
        alu_bus.full = 0;
        disp(4'd1, 4'd9, 1, 32'd11, 0, 1, 32'd22, 0);
        tick(1, "rst_upd");
        idle();
        tick(0, "rst_iss");
        #2 rst = 0;
        #1;
        model_reset();
        check_outputs("async_rst");
        chk("async_rst_const_en", 32'(alu_bus.calc_enable), 32'd0);
        rst = 1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
